// File: rtl/async_fifo_cdc.sv
// Dual-clock FIFO for AXI channel payloads with gray-coded pointer crossing,
// fill-level counts, almost-full/almost-empty and sticky overflow/underflow flags.
module async_fifo_cdc #(
   parameter int DATA_W        = 45,
   parameter int ADDR_W        = 2,
   parameter int SYNC_STAGES   = 2,
   parameter int AFULL_THRESH  = (1 << ADDR_W) - 1,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              r_clk,
   input  logic              r_rst,
   input  logic              w_push,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_full,
   output logic              w_almost_full,
   output logic [ADDR_W:0]   w_count,
   output logic              w_overflow,
   input  logic              r_pop,
   output logic [DATA_W-1:0] r_data,
   output logic              r_empty,
   output logic              r_almost_empty,
   output logic [ADDR_W:0]   r_count,
   output logic              r_underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int PW    = ADDR_W + 1;

   typedef logic [PW-1:0] ptr_t;

   if (ADDR_W < 1) begin : g_bad_addr_w
      $error("async_fifo_cdc: ADDR_W must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("async_fifo_cdc: SYNC_STAGES must be >= 2");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("async_fifo_cdc: AFULL_THRESH must be within 1..DEPTH");
   end
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
      $error("async_fifo_cdc: AEMPTY_THRESH must be within 0..DEPTH-1");
   end

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   ptr_t wPtr_q, wPtr_d, wGray_q;
   ptr_t rPtr_q, rPtr_d, rGray_q;
   ptr_t rSync_q [SYNC_STAGES];
   ptr_t wSync_q [SYNC_STAGES];
   ptr_t rPtrSync, wPtrSync;
   ptr_t wCount, rCount;
   logic wFull, rEmpty, wAccept, rAccept;
   logic wOverflow_q, wOverflow_d;
   logic rUnderflow_q, rUnderflow_d;

   // Write side: occupancy is judged against the possibly stale read pointer,
   // so it can only over-report and never lets a push overwrite unread data.
   always_comb begin
      rPtrSync    = gray2bin(rSync_q[SYNC_STAGES-1]);
      wCount      = wPtr_q - rPtrSync;
      wFull       = (wCount == ptr_t'(DEPTH));
      wAccept     = w_push & ~wFull;
      wPtr_d      = wAccept ? wPtr_q + ptr_t'(1) : wPtr_q;
      wOverflow_d = wOverflow_q | (w_push & wFull);
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         wPtr_q      <= '0;
         wGray_q     <= '0;
         wOverflow_q <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            rSync_q[i] <= '0;
         end
      end else begin
         wPtr_q      <= wPtr_d;
         wGray_q     <= bin2gray(wPtr_q);
         wOverflow_q <= wOverflow_d;
         rSync_q[0]  <= rGray_q;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rSync_q[i] <= rSync_q[i-1];
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (wAccept) begin
         mem_q[wPtr_q[ADDR_W-1:0]] <= w_data;
      end
   end

   // Read side mirrors the write side: a stale write pointer only under-reports.
   always_comb begin
      wPtrSync     = gray2bin(wSync_q[SYNC_STAGES-1]);
      rCount       = wPtrSync - rPtr_q;
      rEmpty       = (rCount == '0);
      rAccept      = r_pop & ~rEmpty;
      rPtr_d       = rAccept ? rPtr_q + ptr_t'(1) : rPtr_q;
      rUnderflow_d = rUnderflow_q | (r_pop & rEmpty);
   end

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         rPtr_q       <= '0;
         rGray_q      <= '0;
         rUnderflow_q <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            wSync_q[i] <= '0;
         end
      end else begin
         rPtr_q       <= rPtr_d;
         rGray_q      <= bin2gray(rPtr_q);
         rUnderflow_q <= rUnderflow_d;
         wSync_q[0]   <= wGray_q;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            wSync_q[i] <= wSync_q[i-1];
         end
      end
   end

   assign w_full         = wFull;
   assign w_count        = wCount;
   assign w_almost_full  = (wCount >= ptr_t'(AFULL_THRESH));
   assign w_overflow     = wOverflow_q;

   assign r_data         = mem_q[rPtr_q[ADDR_W-1:0]];
   assign r_empty        = rEmpty;
   assign r_count        = rCount;
   assign r_almost_empty = (rCount <= ptr_t'(AEMPTY_THRESH));
   assign r_underflow    = rUnderflow_q;

endmodule

// File: tb/tb_async_fifo_cdc.sv
// Self-checking bench for async_fifo_cdc: directed fill/drain, flag and latency
// checks, then randomized cross-clock traffic against a queue reference model.
module tb_async_fifo_cdc;

   localparam int DATA_W = 45;
   localparam int ADDR_W = 3;
   localparam int SYNC   = 2;
   localparam int AFULL  = 6;
   localparam int AEMPTY = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              wClk = 1'b0;
   logic              rClk = 1'b0;
   logic              wRst = 1'b1;
   logic              rRst = 1'b1;
   logic              wPush = 1'b0;
   logic              rPop = 1'b0;
   logic [DATA_W-1:0] wData = '0;
   logic              wFull, wAlmostFull, wOverflow;
   logic              rEmpty, rAlmostEmpty, rUnderflow;
   logic [ADDR_W:0]   wCount, rCount;
   logic [DATA_W-1:0] rData;

   int wHalf = 5;
   int rHalf = 13;
   int nCompared = 0;
   int nMismatched = 0;
   logic [DATA_W-1:0] modelQ [$];
   logic wDone;
   int   totalAcc;

   async_fifo_cdc #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC),
      .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
   ) dut (
      .w_clk(wClk), .w_rst(wRst), .r_clk(rClk), .r_rst(rRst),
      .w_push(wPush), .w_data(wData), .w_full(wFull),
      .w_almost_full(wAlmostFull), .w_count(wCount), .w_overflow(wOverflow),
      .r_pop(rPop), .r_data(rData), .r_empty(rEmpty),
      .r_almost_empty(rAlmostEmpty), .r_count(rCount), .r_underflow(rUnderflow)
   );

   // Half periods are variables so the clock ratio can change between phases.
   always begin
      #(wHalf);
      wClk = ~wClk;
   end

   always begin
      #(rHalf);
      rClk = ~rClk;
   end

   initial begin
      #4000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyReset();
      wRst  = 1'b1;
      rRst  = 1'b1;
      wPush = 1'b0;
      rPop  = 1'b0;
      fork
         repeat (SYNC + 3) @(posedge wClk);
         repeat (SYNC + 3) @(posedge rClk);
      join
      @(negedge wClk) wRst = 1'b0;
      @(negedge rClk) rRst = 1'b0;
      modelQ.delete();
   endtask

   task automatic pushWord(input logic [DATA_W-1:0] d);
      logic acc;
      @(negedge wClk);
      wPush = 1'b1;
      wData = d;
      acc   = !wFull;
      @(posedge wClk);
      #1 wPush = 1'b0;
      if (acc) modelQ.push_back(d);
   endtask

   task automatic popWord();
      logic acc;
      @(negedge rClk);
      acc = !rEmpty;
      if (acc) begin
         if (modelQ.size() == 0) checkOutput("pop_spurious", 64'd1, 64'd0);
         else checkOutput("pop_data", 64'(rData), 64'(modelQ[0]));
      end
      rPop = 1'b1;
      @(posedge rClk);
      #1 rPop = 1'b0;
      if (acc && modelQ.size() != 0) void'(modelQ.pop_front());
   endtask

   task automatic waitReadCount(input int n, input string tag);
      for (int i = 0; i < 20 && rCount != n[ADDR_W:0]; i++) begin
         @(posedge rClk);
         #1;
      end
      checkOutput(tag, 64'(rCount), 64'(n));
   endtask

   task automatic waitWriteCount(input int n, input string tag);
      for (int i = 0; i < 20 && wCount != n[ADDR_W:0]; i++) begin
         @(posedge wClk);
         #1;
      end
      checkOutput(tag, 64'(wCount), 64'(n));
   endtask

   // One round of random traffic; acceptance follows the rule push & ~full,
   // and every delivered word must match the head of the reference queue.
   task automatic applyStimulus(input int attempts);
      wDone    = 1'b0;
      totalAcc = 0;
      fork
         begin
            int acc = 0;
            for (int i = 0; i < attempts; i++) begin
               @(negedge wClk);
               checkOutput("w_count_bound", 64'(wCount <= DEPTH), 64'd1);
               if ($urandom_range(0, 99) < 60 && !wFull) begin
                  logic [DATA_W-1:0] d;
                  d = DATA_W'({$urandom(), $urandom()});
                  wPush = 1'b1;
                  wData = d;
                  modelQ.push_back(d);
                  acc++;
               end else begin
                  wPush = 1'b0;
               end
            end
            @(negedge wClk) wPush = 1'b0;
            totalAcc = acc;
            wDone    = 1'b1;
         end
         begin
            int got = 0;
            int cyc = 0;
            while (!(wDone && got == totalAcc) && cyc < 30000) begin
               @(negedge rClk);
               cyc++;
               if (($urandom_range(0, 99) < 60 || wDone) && !rEmpty) begin
                  rPop = 1'b1;
                  if (modelQ.size() == 0) checkOutput("stress_spurious", 64'd1, 64'd0);
                  else checkOutput("stress_data", 64'(rData), 64'(modelQ.pop_front()));
                  got++;
               end else begin
                  rPop = 1'b0;
               end
            end
            @(negedge rClk) rPop = 1'b0;
            if (cyc >= 30000) checkOutput("stress_timeout", 64'(got), 64'(totalAcc));
         end
      join
   endtask

   initial begin
      applyReset();
      checkOutput("rst_w_full", 64'(wFull), 64'd0);
      checkOutput("rst_w_count", 64'(wCount), 64'd0);
      checkOutput("rst_w_afull", 64'(wAlmostFull), 64'd0);
      checkOutput("rst_w_ovf", 64'(wOverflow), 64'd0);
      checkOutput("rst_r_empty", 64'(rEmpty), 64'd1);
      checkOutput("rst_r_count", 64'(rCount), 64'd0);
      checkOutput("rst_r_aempty", 64'(rAlmostEmpty), 64'd1);
      checkOutput("rst_r_unf", 64'(rUnderflow), 64'd0);

      for (int i = 1; i <= DEPTH; i++) begin
         pushWord(DATA_W'(i));
         checkOutput("fill_w_count", 64'(wCount), 64'(i));
         checkOutput("fill_w_afull", 64'(wAlmostFull), 64'(i >= AFULL));
         checkOutput("fill_w_full", 64'(wFull), 64'(i == DEPTH));
      end

      // The dropped word never enters the reference queue, so the drain must skip it.
      pushWord(DATA_W'(64'hDEAD));
      checkOutput("ovf_set", 64'(wOverflow), 64'd1);
      checkOutput("ovf_count", 64'(wCount), 64'(DEPTH));
      repeat (3) @(posedge wClk);
      #1 checkOutput("ovf_sticky", 64'(wOverflow), 64'd1);

      waitReadCount(DEPTH, "sync_r_count");
      checkOutput("sync_r_empty", 64'(rEmpty), 64'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         popWord();
         checkOutput("drain_r_count", 64'(rCount), 64'(DEPTH - i));
         checkOutput("drain_r_aempty", 64'(rAlmostEmpty), 64'((DEPTH - i) <= AEMPTY));
      end
      checkOutput("drain_r_empty", 64'(rEmpty), 64'd1);

      popWord();
      checkOutput("unf_set", 64'(rUnderflow), 64'd1);
      checkOutput("unf_r_count", 64'(rCount), 64'd0);
      waitWriteCount(0, "drain_w_count");
      checkOutput("ovf_still_set", 64'(wOverflow), 64'd1);
      pushWord(DATA_W'(5));
      waitReadCount(1, "after_unf_r_count");
      checkOutput("after_unf_data", 64'(rData), 64'd5);
      popWord();
      checkOutput("after_unf_empty", 64'(rEmpty), 64'd1);
      checkOutput("unf_sticky", 64'(rUnderflow), 64'd1);

      wHalf = 5;
      rHalf = 5;
      applyReset();
      checkOutput("rst2_w_ovf", 64'(wOverflow), 64'd0);
      checkOutput("rst2_r_unf", 64'(rUnderflow), 64'd0);
      @(negedge wClk);
      wPush = 1'b1;
      wData = DATA_W'(64'h77);
      modelQ.push_back(DATA_W'(64'h77));
      @(posedge wClk);
      #1 wPush = 1'b0;
      repeat (2) @(posedge rClk);
      #1 checkOutput("lat_empty_edge2", 64'(rEmpty), 64'd1);
      repeat (2) @(posedge rClk);
      #1 checkOutput("lat_ready_edge4", 64'(rEmpty), 64'd0);
      popWord();

      for (int round = 0; round < 4; round++) begin
         wHalf = $urandom_range(4, 12);
         rHalf = $urandom_range(4, 12);
         applyReset();
         applyStimulus(1500);
         waitWriteCount(0, "stress_w_count_end");
         checkOutput("stress_r_empty", 64'(rEmpty), 64'd1);
         checkOutput("stress_model_empty", 64'(modelQ.size()), 64'd0);
         checkOutput("stress_ovf", 64'(wOverflow), 64'd0);
         checkOutput("stress_unf", 64'(rUnderflow), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/async_fifo_cdc.md
# async_fifo_cdc

Parametrised dual-clock FIFO carrying AXI channel payloads (AW/W/AR/R/B) between the bus clock and a slave-side clock domain. It generalises the fixed 45-bit, 4-entry channel FIFO to arbitrary width, depth and synchronizer length. It adds fill-level counts, almost-full/almost-empty flags and sticky overflow/underflow error flags. One instance per channel per crossing.

## Interface
- DATA_W, default 45: payload width in bits.
- ADDR_W, default 2: DEPTH = 2**ADDR_W entries; pointers are ADDR_W+1 bits.
- SYNC_STAGES, default 2: flip-flop stages per gray-pointer synchronizer.
- AFULL_THRESH, default DEPTH-1: w_almost_full when w_count >= this value.
- AEMPTY_THRESH, default 1: r_almost_empty when r_count <= this value.
- Elaboration error unless ADDR_W>=1, SYNC_STAGES>=2, 1<=AFULL_THRESH<=DEPTH and 0<=AEMPTY_THRESH<DEPTH.

Ports:
- w_clk  in  1  write-domain clock.
- w_rst  in  1  write-domain reset, synchronous, active-high.
- r_clk  in  1  read-domain clock.
- r_rst  in  1  read-domain reset, synchronous, active-high.
- w_push  in  1  write request.
- w_data  in  DATA_W  write payload.
- w_full  out  1  no free entry.
- w_almost_full  out  1  w_count >= AFULL_THRESH.
- w_count  out  ADDR_W+1  occupancy seen by the write side (0..DEPTH).
- w_overflow  out  1  sticky: push attempted while full.
- r_pop  in  1  read acknowledge.
- r_data  out  DATA_W  head entry, first-word-fall-through.
- r_empty  out  1  no valid entry.
- r_almost_empty  out  1  r_count <= AEMPTY_THRESH.
- r_count  out  ADDR_W+1  occupancy seen by the read side.
- r_underflow  out  1  sticky: pop attempted while empty.

## Operation
- Storage: DEPTH x DATA_W array, written only in the w_clk domain. It is not reset.
- w_ptr and r_ptr are binary, ADDR_W+1 bits, and wrap modulo 2**(ADDR_W+1). The low ADDR_W bits address memory.
- Write accepted = w_push & ~w_full. On accept: mem[w_ptr[ADDR_W-1:0]] <= w_data and w_ptr increments.
- Push while full: dropped. Memory and w_ptr are unchanged and w_overflow sets.
- Read accepted = r_pop & ~r_empty. On accept, r_ptr increments.
- Pop while empty: r_ptr is unchanged and r_underflow sets.
- Pointer crossing: each pointer is converted to gray and registered in its own domain (glitch-free source). It then passes through SYNC_STAGES flops in the other domain and is converted back to binary.
- w_count = w_ptr - r_ptr_sync (mod 2**(ADDR_W+1)); w_full = (w_count == DEPTH).
- r_count = w_ptr_sync - r_ptr (mod 2**(ADDR_W+1)); r_empty = (r_count == 0).
- All flags and counts are combinational from the local pointer and the synchronized pointer.
- Flags are conservative. w_full and w_count may over-report occupancy until a read propagates across; r_empty and r_count may under-report until a write propagates. The FIFO never overwrites unread data and never returns unwritten data.
- r_data = mem[r_ptr[ADDR_W-1:0]]. It is valid only while r_empty=0 and is don't-care otherwise.
- Simultaneous push and pop on a non-full, non-empty FIFO: both are accepted.
- Sticky flags clear only on their own domain reset.
- Reset values:
  - w_rst clears w_ptr, the write gray register and the read-pointer synchronizer. Outputs: w_full=0, w_count=0, w_almost_full=0, w_overflow=0.
  - r_rst clears r_ptr, the read gray register and the write-pointer synchronizer. Outputs: r_empty=1, r_count=0, r_almost_empty=1, r_underflow=0.
- Reset mid-operation: w_rst and r_rst must overlap, each held for at least SYNC_STAGES+1 cycles of its own clock. All contents are discarded. Asserting only one domain's reset is unsupported.

## Timing
- Write visibility: an accepted write on w_clk edge N updates w_ptr at N and the write gray register at N+1. r_empty/r_count reflect it after SYNC_STAGES further r_clk edges, plus up to one extra r_clk edge of phase uncertainty.
- Read visibility: symmetric. A pop is reflected in w_full/w_count after 1 r_clk edge + SYNC_STAGES w_clk edges (+1).
- Local effects are immediate. w_count rises, and w_full can assert, in the same cycle as the accepting edge. r_count falls, and r_empty can assert, likewise on the read side.
- Throughput: one push per w_clk and one pop per r_clk, sustained, when neither side is stalled by its flag.

## Test plan
- Fill/drain (DATA_W=45, ADDR_W=2, w_clk 100 MHz, r_clk 37 MHz): push 0x1,0x2,0x3,0x4 -> w_full=1 and w_count=4 after the 4th edge; pop all -> r_data reads 0x1..0x4 in order, then r_empty=1.
- Overflow: on a full FIFO, push 0xDEAD -> w_overflow=1 and stays 1; the drained sequence excludes 0xDEAD.
- Underflow: pop on an empty FIFO after reset -> r_underflow=1 and r_ptr unchanged. A subsequent push of 0x5 then pop returns 0x5.
- Latency (equal-frequency clocks, SYNC_STAGES=2): single push at w edge 0 -> r_empty falls after r edge 3 and no later than r edge 4.
- Thresholds (ADDR_W=3, AFULL_THRESH=6, AEMPTY_THRESH=2): push 6 -> w_almost_full=1 at the 6th edge; after sync, pop until r_count=2 -> r_almost_empty=1.
- Wrap and stress: 10k random push/pop with random clock ratios 1:3..3:1 and ADDR_W=4, SYNC_STAGES=3. The scoreboard shows in-order, lossless delivery; w_count<=DEPTH always; both sticky flags stay 0.
